// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with fixed or round-robin select and one registered output stage
module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       up_valid,
  input  logic [N*WIDTH-1:0] up_data,
  output logic [N-1:0]       up_ready,
  output logic               down_valid,
  output logic [WIDTH-1:0]   down_data,
  output logic [SEL_W-1:0]   down_chan,
  input  logic               down_ready
);
  logic [N-1:0]     grant;
  logic [N-1:0]     fire;
  logic             space;
  logic [SEL_W-1:0] scan_idx;
  logic [SEL_W-1:0] fire_chan;
  logic             down_valid_q, down_valid_d;
  logic [WIDTH-1:0] down_data_q, down_data_d;
  logic [SEL_W-1:0] down_chan_q, down_chan_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  assign space = ~down_valid_q | down_ready;
  assign up_ready = grant & {N{space}} & {N{rst_n}};
  assign fire = up_valid & up_ready;
  assign down_valid = down_valid_q;
  assign down_data = down_data_q;
  assign down_chan = down_chan_q;

  // one-hot grant: external index in fixed mode, first valid at or after rr_ptr in round-robin
  always_comb begin
    grant = '0;
    scan_idx = '0;
    if (!mode) begin
      if (int'(sel) < N) grant[sel] = 1'b1;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        scan_idx = SEL_W'((int'(rr_ptr_q) + k) % N);
        if (up_valid[scan_idx]) begin
          grant = '0;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  // output register next state: load on upstream transfer, drain on downstream transfer
  always_comb begin
    fire_chan = '0;
    for (int k = 0; k < N; k++) if (fire[k]) fire_chan = SEL_W'(k);
    down_valid_d = down_valid_q & ~down_ready;
    down_data_d = down_data_q;
    down_chan_d = down_chan_q;
    rr_ptr_d = rr_ptr_q;
    if (|fire) begin
      down_valid_d = 1'b1;
      down_data_d = up_data[int'(fire_chan)*WIDTH +: WIDTH];
      down_chan_d = fire_chan;
      if (mode) rr_ptr_d = (int'(fire_chan) == N - 1) ? '0 : fire_chan + 1'b1;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      down_valid_q <= 1'b0;
      down_data_q <= '0;
      down_chan_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      down_valid_q <= down_valid_d;
      down_data_q <= down_data_d;
      down_chan_q <= down_chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenario tests for stream_mux_rr
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  up_valid;
  logic [15:0] up_data;
  logic [3:0]  up_ready;
  logic        down_valid;
  logic [3:0]  down_data;
  logic [1:0]  down_chan;
  logic        down_ready;
  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(4), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .down_valid(down_valid), .down_data(down_data), .down_chan(down_chan),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; up_valid = 4'hf; up_data = 16'hdcba; down_ready = 1'b1;
    tick(); tick();
    #1;
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", down_valid); end
    checks++; if (down_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", down_data); end
    checks++; if (down_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", down_chan); end
    checks++; if (up_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", up_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (up_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", up_ready); end
  endtask

  task automatic test_rr_fair();
    logic [1:0] exp_c;
    logic [3:0] exp_d;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_c = 2'(i % 4);
      exp_d = 4'(10 + i % 4);
      checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, down_valid); end
      checks++; if (down_chan !== exp_c) begin errors++; $display("FAIL rr_chan[%0d]: got %0d expected %0d", i, down_chan, exp_c); end
      checks++; if (down_data !== exp_d) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, down_data, exp_d); end
    end
  endtask

  task automatic test_fixed();
    logic [3:0] exp_d;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      exp_d = 4'(10 + i);
      checks++; if (down_data !== exp_d) begin errors++; $display("FAIL fixed_data[%0d]: got %h expected %h", i, down_data, exp_d); end
      checks++; if (down_chan !== 2'(i)) begin errors++; $display("FAIL fixed_chan[%0d]: got %0d expected %0d", i, down_chan, i); end
    end
    sel = 2'd2; up_data = {4'bxxxx, 12'hcba};
    #1;
    checks++; if (up_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready_sel2: got %b expected 0100", up_ready); end
    tick();
    checks++; if (down_data !== 4'hc) begin errors++; $display("FAIL fixed_x_isolation: got %h expected c", down_data); end
    up_data = 16'hdcba; up_valid = 4'b0000; sel = 2'd1;
    #1;
    checks++; if (up_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready_no_valid: got %b expected 0010", up_ready); end
    tick();
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain_valid: got %b expected 0", down_valid); end
    checks++; if (down_data !== 4'hc) begin errors++; $display("FAIL fixed_drain_hold: got %h expected c", down_data); end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_r [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [1:0] exp_c [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mode = 1'b1; up_valid = 4'b1010; down_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (up_ready !== exp_r[i]) begin errors++; $display("FAIL sparse_ready[%0d]: got %b expected %b", i, up_ready, exp_r[i]); end
      tick();
      checks++; if (down_chan !== exp_c[i]) begin errors++; $display("FAIL sparse_chan[%0d]: got %0d expected %0d", i, down_chan, exp_c[i]); end
    end
  endtask

  task automatic test_back_pressure();
    mode = 1'b0; sel = 2'd1; up_valid = 4'hf; down_ready = 1'b1;
    tick();
    checks++; if (down_data !== 4'hb) begin errors++; $display("FAIL bp_load: got %h expected b", down_data); end
    down_ready = 1'b0; sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (up_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, up_ready); end
      tick();
      checks++; if (down_data !== 4'hb || down_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/b", i, down_valid, down_data); end
    end
    down_ready = 1'b1;
    #1;
    checks++; if (up_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected 0100", up_ready); end
    tick();
    checks++; if (down_valid !== 1'b1 || down_data !== 4'hc || down_chan !== 2'd2) begin errors++; $display("FAIL bp_no_bubble: got %b/%h/%0d expected 1/c/2", down_valid, down_data, down_chan); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; up_valid = 4'hf; down_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (down_data !== 4'hc || down_chan !== 2'd2) begin errors++; $display("FAIL mid_pre: got %h/%0d expected c/2", down_data, down_chan); end
    rst_n = 1'b0;
    #1;
    checks++; if (up_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0000", up_ready); end
    tick();
    checks++; if (down_valid !== 1'b0 || down_data !== 4'h0 || down_chan !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %b/%h/%0d expected 0/0/0", down_valid, down_data, down_chan); end
    rst_n = 1'b1;
    #1;
    checks++; if (up_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_reset: got %b expected 0001", up_ready); end
    tick();
    checks++; if (down_chan !== 2'd0 || down_data !== 4'ha) begin errors++; $display("FAIL mid_resume: got %0d/%h expected 0/a", down_chan, down_data); end
  endtask

  initial begin
    test_reset();
    test_rr_fair();
    test_fixed();
    test_sparse();
    test_back_pressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- N-channel streaming multiplexer: successor to the combinational array-index mux.
- Each input channel carries WIDTH-bit data with a valid/ready handshake; one registered output stream.
- Two selection modes: fixed (external index, as in the combinational mux) and round-robin arbitration.
- Sits between multiple producers and a single consumer; one output register stage gives one cycle of latency.

Parameters:
- WIDTH, 4, data width of every channel.
- N, 4, number of input channels; must be ≥2.
- SEL_W, $clog2(N), width of the select and channel-index fields; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode = 0.
- up_valid  input  N  per-channel valid; bit i belongs to channel i.
- up_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- up_ready  output  N  per-channel ready; at most one bit set.
- down_valid  output  1  output register holds a beat.
- down_data  output  WIDTH  registered beat data.
- down_chan  output  SEL_W  source channel of the registered beat.
- down_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset, rst_n = 0 at posedge:
  - down_valid = 0, down_data = 0, down_chan = 0, rr_ptr = 0.
  - up_ready is combinational and reads 0 while rst_n = 0.
- Reset mid-operation discards the held beat; no transfer completes in the reset cycle.
- Combinational grant (one-hot, N bits):
  - mode = 0: grant = onehot(sel); sel ≥ N grants nothing.
  - mode = 1: first channel with up_valid set, scanning rr_ptr, rr_ptr+1, … wrapping mod N. No valid gives grant = 0.
- Space condition: space = ~down_valid | down_ready.
- up_ready = grant & {N{space}} & {N{rst_n}}. Ready is independent of the granted channel's own up_valid in mode 0.
- Upstream transfer on channel i: up_valid[i] & up_ready[i]. At the next posedge:
  - down_valid ← 1, down_data ← channel i data, down_chan ← i.
  - mode = 1 only: rr_ptr ← (i+1) mod N, wrapping from N-1 to 0.
  - mode = 0: rr_ptr is unchanged.
- Downstream transfer (down_valid & down_ready) with no upstream transfer in the same cycle: down_valid ← 0. down_data and down_chan hold their last values.
- Simultaneous downstream and upstream transfer: the new beat replaces the old one. Full throughput is 1 beat/cycle, no bubble.
- Stall (down_valid = 1, down_ready = 0): up_ready = 0; output register holds stable.
- Latency: an accepted beat appears on down_* exactly 1 cycle after its transfer edge.
- Mode or sel change mid-stream takes effect on the next grant evaluation. A beat already in the output register is unaffected.
- No data is dropped or duplicated. Every upstream transfer produces exactly one downstream beat unless reset intervenes.
- X on up_data of an unselected channel must not propagate to down_data.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with all up_valid = 1 -> down_valid = 0, down_data = 0, down_chan = 0, up_ready = 0; release -> in mode 1, channel 0 is granted first.
- Fixed select: mode = 0, data 'ha/'hb/'hc/'hd on channels 0-3, all valid, down_ready = 1, sel swept 0..3 -> down_data = 'ha, 'hb, 'hc, 'hd one cycle after each sel, down_chan = sel. Channel 3 driven 'x with sel = 2 -> down_data = 'hc, no X.
- Round-robin fairness: mode = 1, all four channels valid continuously, down_ready = 1 -> down_chan sequence 0, 1, 2, 3, 0, 1, one beat per cycle after the first.
- Sparse round-robin: mode = 1, only channels 1 and 3 valid, rr_ptr = 0 -> grants alternate 1, 3, 1, 3; channels 0 and 2 never see up_ready = 1.
- Back-pressure: down_ready = 0 for 3 cycles while holding beat 'hb -> down_data stays 'hb, up_ready = 0; down_ready = 1 -> next beat loads on the same edge, no bubble, no loss.
- Reset mid-stream: assert rst_n = 0 while down_valid = 1, down_data = 'hc -> next cycle down_valid = 0, rr_ptr = 0; the resumed stream starts at channel 0.
